// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serializes I-cache and D-cache block requests onto
// one registered main-memory port and routes completions back to the owner.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic i_req;
  logic d_req;
  logic grant;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;
  // On a tie the port that did not win last time goes next.
  assign grant = (i_req && d_req) ? ~last_grant_q : d_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req || d_req) state_d = BUSY;
      BUSY:    if (mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_ready = (state_q == RESP) && (owner_q == OWN_I);
    d_ready = (state_q == RESP) && (owner_q == OWN_D);
  end

  // A simultaneous read+write is a write; the read bit only matters alone.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d      = grant;
          last_grant_d = grant;
          if (grant == OWN_D) begin
            mem_write_d = d_write;
            mem_read_d  = d_read & ~d_write;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_write_d = i_write;
            mem_read_d  = i_read & ~i_write;
            mem_addr_d  = i_addr;
            mem_wdata_d = i_wdata;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            if (owner_q == OWN_D) d_rdata_d = mem_rdata;
            else                  i_rdata_d = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= OWN_I;
      last_grant_q <= OWN_D;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level reference model of the
// arbiter plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Reference model: one outstanding transaction record plus timing rules.
  bit            m_active;
  bit            m_owner;
  bit            m_write;
  bit [AW-1:0]   m_addr;
  bit [DW-1:0]   m_wdata;
  bit            m_last;
  int            m_free;
  int            m_resp;
  bit [DW-1:0]   m_i_rdata, m_d_rdata;
  bit            grants[$];
  bit            ready_seq[$];

  // Memory responder state.
  int  mem_cnt;
  int  mem_lat_cfg;
  int  mem_data_mode;
  bit  mem_done;
  bit  spurious_en;
  logic [DW-1:0] mem_fixed;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: got %h, want %h", name, edge_n, act, exp);
    end
  endtask

  task automatic reset_model();
    m_active  = 0;
    m_owner   = 0;
    m_write   = 0;
    m_addr    = '0;
    m_wdata   = '0;
    m_last    = 1;
    m_free    = 0;
    m_resp    = -1;
    m_i_rdata = '0;
    m_d_rdata = '0;
  endtask

  task automatic update_model();
    bit ir, dr, own;
    m_resp = -1;
    ir = i_read | i_write;
    dr = d_read | d_write;
    if (m_active) begin
      if (mem_ready) begin
        m_active = 0;
        if (!m_write) begin
          if (m_owner) m_d_rdata = mem_rdata;
          else         m_i_rdata = mem_rdata;
        end
        m_resp = int'(m_owner);
        m_free = edge_n + 2;
      end
    end else if (edge_n >= m_free && (ir || dr)) begin
      own      = (ir && dr) ? !m_last : dr;
      m_last   = own;
      m_active = 1;
      m_owner  = own;
      m_write  = own ? d_write : i_write;
      m_addr   = own ? d_addr : i_addr;
      m_wdata  = own ? d_wdata : i_wdata;
      grants.push_back(own);
    end
  endtask

  task automatic checkOutput();
    check("mem_read",  mem_read,  (m_active && !m_write));
    check("mem_write", mem_write, (m_active && m_write));
    check("mem_addr",  mem_addr,  m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("i_ready",   i_ready,   (m_resp == 0));
    check("d_ready",   d_ready,   (m_resp == 1));
    check("i_rdata",   i_rdata,   m_i_rdata);
    check("d_rdata",   d_rdata,   m_d_rdata);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    update_model();
    checkOutput();
    if (i_ready) ready_seq.push_back(1'b0);
    if (d_ready) ready_seq.push_back(1'b1);
  endtask

  function automatic logic [DW-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_lat(input int l);
    mem_lat_cfg = l;
    mem_cnt     = (l < 0) ? int'($urandom_range(0, 4)) : l;
  endtask

  task automatic mem_service();
    mem_ready = 1'b0;
    if (mem_read || mem_write) begin
      if (!mem_done) begin
        if (mem_cnt == 0) begin
          mem_ready = 1'b1;
          mem_done  = 1'b1;
          case (mem_data_mode)
            1:       mem_rdata = mem_fixed;
            2:       mem_rdata = {{(DW-AW){1'b0}}, mem_addr};
            default: mem_rdata = rand_blk();
          endcase
        end else begin
          mem_cnt--;
        end
      end
    end else begin
      mem_done = 1'b0;
      mem_cnt  = (mem_lat_cfg < 0) ? int'($urandom_range(0, 4)) : mem_lat_cfg;
      if (spurious_en && $urandom_range(0, 7) == 0) begin
        mem_ready = 1'b1;
        mem_rdata = rand_blk();
      end
    end
  endtask

  task automatic rand_port(inout logic rd, inout logic wr, inout logic [AW-1:0] ad,
                           inout logic [DW-1:0] wd);
    int k;
    if (!(rd || wr)) begin
      if ($urandom_range(0, 3) == 0) begin
        k  = int'($urandom_range(0, 2));
        rd = (k != 1);
        wr = (k != 0);
        ad = AW'($urandom);
        wd = rand_blk();
      end
    end else if ($urandom_range(0, 7) == 0) begin
      ad = AW'($urandom);
      wd = rand_blk();
    end
  endtask

  // Each cache drops its request on the edge that ends its ready pulse.
  task automatic applyStimulus(input bit rand_mode);
    if (i_ready) begin i_read = 1'b0; i_write = 1'b0; end
    if (d_ready) begin d_read = 1'b0; d_write = 1'b0; end
    if (rand_mode) begin
      rand_port(i_read, i_write, i_addr, i_wdata);
      rand_port(d_read, d_write, d_addr, d_wdata);
    end
    mem_service();
  endtask

  task automatic wait_ready(input bit port, input int budget, input string name);
    bit got = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (port ? d_ready : i_ready) got = 1;
      if (got) break;
      applyStimulus(0);
    end
    check({name, "_ready_seen"}, got, 1'b1);
  endtask

  task automatic clear_inputs();
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rdata = '0; mem_done = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    set_lat(mem_lat_cfg);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_read"},  mem_read,  '0);
    check({tag, "_mem_write"}, mem_write, '0);
    check({tag, "_mem_addr"},  mem_addr,  '0);
    check({tag, "_mem_wdata"}, mem_wdata, '0);
    check({tag, "_i_rdata"},   i_rdata,   '0);
    check({tag, "_d_rdata"},   d_rdata,   '0);
    check({tag, "_i_ready"},   i_ready,   '0);
    check({tag, "_d_ready"},   d_ready,   '0);
  endtask

  initial begin
    bit saw_d;
    bit exp_seq [6];
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    clear_inputs();
    mem_data_mode = 0;
    spurious_en   = 0;
    mem_fixed     = '0;
    set_lat(0);
    reset_model();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single I read");
    mem_data_mode = 1;
    mem_fixed     = {16{8'hA5}};
    set_lat(3);
    i_read = 1'b1;
    i_addr = 28'h0000010;
    step();
    check("single_mem_read", mem_read, 1'b1);
    check("single_mem_addr", mem_addr, 28'h0000010);
    applyStimulus(0);
    saw_d = 0;
    for (int c = 0; c < 20 && !i_ready; c++) begin
      step();
      if (d_ready) saw_d = 1;
      if (!i_ready) applyStimulus(0);
    end
    check("single_i_ready", i_ready, 1'b1);
    check("single_i_rdata", i_rdata, {16{8'hA5}});
    check("single_no_d_ready", saw_d, 1'b0);
    applyStimulus(0);
    step();
    check("single_ready_one_cycle", i_ready, 1'b0);
    applyStimulus(0);

    $display("[TB] simultaneous requests");
    mem_data_mode = 2;
    set_lat(0);
    do_reset();
    i_read = 1'b1; i_addr = 28'h1;
    d_read = 1'b1; d_addr = 28'h2;
    wait_ready(1'b0, 20, "sim_i");
    check("sim_i_rdata", i_rdata, 128'h1);
    applyStimulus(0);
    wait_ready(1'b1, 20, "sim_d");
    check("sim_d_rdata", d_rdata, 128'h2);
    check("sim_mem_addr", mem_addr, 28'h2);
    applyStimulus(0);

    $display("[TB] fairness");
    set_lat(-1);
    do_reset();
    grants.delete();
    ready_seq.delete();
    for (int c = 0; c < 200 && ready_seq.size() < 6; c++) begin
      i_read = 1'b1; d_read = 1'b1;
      if (!mem_read) begin i_addr = AW'($urandom); d_addr = AW'($urandom); end
      step();
      applyStimulus(0);
    end
    i_read = 0; d_read = 0;
    check("fair_count", ready_seq.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < ready_seq.size()) check($sformatf("fair_ready_%0d", k), ready_seq[k], exp_seq[k]);
      if (k < grants.size())    check($sformatf("fair_grant_%0d", k), grants[k], exp_seq[k]);
    end
    for (int c = 0; c < 12; c++) begin step(); applyStimulus(0); end

    $display("[TB] D write");
    set_lat(2);
    do_reset();
    d_write = 1'b1; d_addr = 28'h3F; d_wdata = 128'h1234;
    step();
    check("dwr_mem_write", mem_write, 1'b1);
    check("dwr_mem_read",  mem_read,  1'b0);
    check("dwr_mem_wdata", mem_wdata, 128'h1234);
    check("dwr_mem_addr",  mem_addr,  28'h3F);
    applyStimulus(0);
    wait_ready(1'b1, 20, "dwr");
    check("dwr_d_rdata", d_rdata, 128'h0);
    applyStimulus(0);

    $display("[TB] reset mid-BUSY");
    set_lat(10);
    do_reset();
    i_read = 1'b1; i_addr = 28'h55;
    step(); applyStimulus(0);
    step(); applyStimulus(0);
    step(); applyStimulus(0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    check("midrst_i_ready_held", i_ready, 1'b0);
    rst = 1'b0;
    reset_model();
    mem_ready = 1'b0; mem_done = 0;
    set_lat(1);
    i_addr = 28'h66;
    wait_ready(1'b0, 20, "after_rst");
    check("after_rst_i_rdata", i_rdata, 128'h66);
    applyStimulus(0);
    for (int c = 0; c < 4; c++) begin step(); applyStimulus(0); end

    $display("[TB] spurious mem_ready");
    mem_ready = 1'b1;
    mem_rdata = rand_blk();
    step();
    check("spur_i_ready", i_ready, 1'b0);
    mem_ready = 1'b0;
    step();
    check("spur_i_rdata", i_rdata, 128'h66);
    check("spur_d_rdata", d_rdata, 128'h0);
    check("spur_mem_read", mem_read, 1'b0);

    $display("[TB] random traffic");
    mem_data_mode = 0;
    spurious_en   = 1;
    set_lat(-1);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      applyStimulus(1);
    end
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      applyStimulus(0);
      i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    end
    check("random_grants_made", (grants.size() > 100), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
